// File: rtl/iq_window_integrator_if.sv
// Result channel of the IQ window integrator: one integrated I/Q pair per
// window, with its window index and saturation flag, under valid/ready.
interface iq_window_integrator_if #(
    parameter int ACC_W = 40,
    parameter int WIN_W = 4
) ();
    logic                    iq_valid;
    logic                    iq_ready;
    logic signed [ACC_W-1:0] i_val;
    logic signed [ACC_W-1:0] q_val;
    logic [WIN_W-1:0]        win_idx;
    logic                    sat;

    modport master (
        output iq_valid, i_val, q_val, win_idx, sat,
        input  iq_ready
    );

    modport slave (
        input  iq_valid, i_val, q_val, win_idx, sat,
        output iq_ready
    );
endinterface

// File: rtl/iq_window_integrator.sv
// IQ window integrator: after a trigger and a programmable delay, sums the
// lanes of accepted I/Q samples over num_windows back-to-back windows of
// window_len accepted cycles each, emitting one saturated result per window.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a trigger edge; config latched on the edge
// S_DELAY | counting down delay_time cycles before the first candidate
// S_INTEG | accepting candidates (skip decimation), closing windows
// S_DRAIN | last window closed; waiting for its result to reach output
module iq_window_integrator #(
    parameter int LANES  = 5,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int DLY_W  = 14,
    parameter int LEN_W  = 11,
    parameter int WIN_W  = 4
) (
    input  logic                           clk100,
    input  logic                           reset,
    input  logic                           trigger,
    input  logic [DLY_W-1:0]               delay_time,
    input  logic [LEN_W-1:0]               window_len,
    input  logic [5:0]                     sample_skip,
    input  logic [WIN_W-1:0]               num_windows,
    input  logic                           in_valid,
    input  logic signed [LANES*PROD_W-1:0] data_i_rot,
    input  logic signed [LANES*PROD_W-1:0] data_q_rot,
    iq_window_integrator_if.master         res_if,
    output logic                           busy,
    output logic                           overrun,
    output logic [15:0]                    missed_trig
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_INTEG = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // control
    logic [1:0]       r_state;
    logic             r_trig_prev;
    logic [DLY_W-1:0] r_dly_cnt;
    logic [LEN_W-1:0] r_len;
    logic [5:0]       r_skip_cfg;
    logic [WIN_W-1:0] r_nwin;
    logic [5:0]       r_skip_cnt;
    logic [LEN_W-1:0] r_acc_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic [15:0]      r_missed;

    // lane-sum stage
    logic             r_stg_v;
    logic             r_stg_first;
    logic             r_stg_last;
    logic             r_stg_final;
    logic [WIN_W-1:0] r_stg_win;
    logic [ACC_W-1:0] r_stg_i;
    logic [ACC_W-1:0] r_stg_q;

    // accumulator
    logic [ACC_W-1:0] r_acc_i;
    logic [ACC_W-1:0] r_acc_q;
    logic             r_acc_sat;
    logic             r_acc_done;
    logic             r_acc_final;
    logic [WIN_W-1:0] r_acc_win;

    // output register
    logic             r_out_v;
    logic [ACC_W-1:0] r_out_i;
    logic [ACC_W-1:0] r_out_q;
    logic [WIN_W-1:0] r_out_win;
    logic             r_out_sat;
    logic             r_overrun;

    logic             w_trig_edge;
    logic [LEN_W-1:0] w_len_eff;
    logic [WIN_W-1:0] w_nwin_eff;
    logic             w_cand;
    logic             w_accept;
    logic             w_win_last;
    logic             w_run_last;
    logic [ACC_W-1:0] w_sum_i;
    logic [ACC_W-1:0] w_sum_q;
    logic [ACC_W:0]   w_add_i;
    logic [ACC_W:0]   w_add_q;

    // Returns {overflow, clamped sum} of two signed ACC_W values.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign w_trig_edge = trigger & ~r_trig_prev;
    assign w_len_eff   = (r_len == '0)  ? LEN_W'(1) : r_len;
    assign w_nwin_eff  = (r_nwin == '0) ? WIN_W'(1) : r_nwin;
    assign w_cand      = (r_state == S_INTEG) && in_valid;
    assign w_accept    = w_cand && (r_skip_cnt == 6'd0);
    assign w_win_last  = w_accept && (r_acc_cnt == w_len_eff - LEN_W'(1));
    assign w_run_last  = w_win_last && (r_win_cnt == w_nwin_eff - WIN_W'(1));

    // Sign-extend every lane to ACC_W and add them up per component.
    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum_i = w_sum_i + {{(ACC_W-PROD_W){data_i_rot[k*PROD_W+PROD_W-1]}},
                                 data_i_rot[k*PROD_W +: PROD_W]};
            w_sum_q = w_sum_q + {{(ACC_W-PROD_W){data_q_rot[k*PROD_W+PROD_W-1]}},
                                 data_q_rot[k*PROD_W +: PROD_W]};
        end
    end

    // First sample of a window starts from zero instead of the old total.
    assign w_add_i = sat_add(r_stg_first ? '0 : r_acc_i, r_stg_i);
    assign w_add_q = sat_add(r_stg_first ? '0 : r_acc_q, r_stg_q);

    // Sequencer: trigger detect, config latch, delay, skip/window counting.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_trig_prev <= 1'b0;
            r_dly_cnt   <= '0;
            r_len       <= '0;
            r_skip_cfg  <= '0;
            r_nwin      <= '0;
            r_skip_cnt  <= '0;
            r_acc_cnt   <= '0;
            r_win_cnt   <= '0;
            r_missed    <= '0;
        end else begin
            r_trig_prev <= trigger;
            if (w_trig_edge && (r_state != S_IDLE) && (r_missed != 16'hFFFF))
                r_missed <= r_missed + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_edge) begin
                        r_dly_cnt  <= delay_time;
                        r_len      <= window_len;
                        r_skip_cfg <= sample_skip;
                        r_nwin     <= num_windows;
                        r_skip_cnt <= '0;
                        r_acc_cnt  <= '0;
                        r_win_cnt  <= '0;
                        r_state    <= (delay_time == '0) ? S_INTEG : S_DELAY;
                    end
                end
                S_DELAY: begin
                    r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                    if (r_dly_cnt == DLY_W'(1))
                        r_state <= S_INTEG;
                end
                S_INTEG: begin
                    if (w_cand) begin
                        if (w_win_last) begin
                            r_skip_cnt <= '0;
                            r_acc_cnt  <= '0;
                            if (w_run_last)
                                r_state <= S_DRAIN;
                            else
                                r_win_cnt <= r_win_cnt + WIN_W'(1);
                        end else begin
                            r_skip_cnt <= (r_skip_cnt == r_skip_cfg) ? 6'd0
                                                                     : r_skip_cnt + 6'd1;
                            if (w_accept)
                                r_acc_cnt <= r_acc_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    if (r_acc_done && r_acc_final)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Lane-sum pipeline stage with window bookkeeping riding alongside.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_stg_v     <= 1'b0;
            r_stg_first <= 1'b0;
            r_stg_last  <= 1'b0;
            r_stg_final <= 1'b0;
            r_stg_win   <= '0;
            r_stg_i     <= '0;
            r_stg_q     <= '0;
        end else begin
            r_stg_v <= w_accept;
            if (w_accept) begin
                r_stg_i     <= w_sum_i;
                r_stg_q     <= w_sum_q;
                r_stg_first <= (r_acc_cnt == '0);
                r_stg_last  <= w_win_last;
                r_stg_final <= w_run_last;
                r_stg_win   <= r_win_cnt;
            end
        end
    end

    // Saturating accumulator; r_acc_done marks a completed window total.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_acc_sat   <= 1'b0;
            r_acc_done  <= 1'b0;
            r_acc_final <= 1'b0;
            r_acc_win   <= '0;
        end else begin
            r_acc_done <= r_stg_v && r_stg_last;
            if (r_stg_v) begin
                r_acc_i     <= w_add_i[ACC_W-1:0];
                r_acc_q     <= w_add_q[ACC_W-1:0];
                r_acc_sat   <= (r_stg_first ? 1'b0 : r_acc_sat) | w_add_i[ACC_W] | w_add_q[ACC_W];
                r_acc_final <= r_stg_final;
                r_acc_win   <= r_stg_win;
            end
        end
    end

    // Output register: loads each window result, overwrites if unread.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_out_v   <= 1'b0;
            r_out_i   <= '0;
            r_out_q   <= '0;
            r_out_win <= '0;
            r_out_sat <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_acc_done) begin
            r_out_v   <= 1'b1;
            r_out_i   <= r_acc_i;
            r_out_q   <= r_acc_q;
            r_out_win <= r_acc_win;
            r_out_sat <= r_acc_sat;
            if (r_out_v && !res_if.iq_ready)
                r_overrun <= 1'b1;
        end else if (r_out_v && res_if.iq_ready) begin
            r_out_v <= 1'b0;
        end
    end

    assign res_if.iq_valid = r_out_v;
    assign res_if.i_val    = r_out_i;
    assign res_if.q_val    = r_out_q;
    assign res_if.win_idx  = r_out_win;
    assign res_if.sat      = r_out_sat;
    assign busy            = (r_state != S_IDLE);
    assign overrun         = r_overrun;
    assign missed_trig     = r_missed;

endmodule
